fp64_sub_pipe: RTL and testbench



---
 rtl/fp64_pkg.sv | 37 +++
 rtl/lzc53.sv | 14 +
 rtl/fp64_sub_pipe.sv | 139 +++++++++++++
 tb/tb_fp64_sub_pipe.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp64_pkg.sv
// Shared widths, special-case classes and stage bundles
// for the pipelined double-precision subtractor.
package fp64_pkg;

  localparam int EXP_W = 11;
  localparam int MAN_W = 52;
  localparam int SIG_W = 53;

  localparam logic [63:0] FP64_SAT  = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] FP64_ZERO = 64'h0;

  typedef enum logic [2:0] {
    NORMAL,
    SAT,
    ZERO,
    PASS_A,
    PASS_NB
  } cls_t;

  typedef struct packed {
    cls_t             cls;
    logic             sx;
    logic [EXP_W-1:0] ex;
    logic             sub;
    logic [SIG_W-1:0] mx;
    logic [SIG_W-1:0] my;
  } align_t;

  typedef struct packed {
    cls_t             cls;
    logic             sx;
    logic [EXP_W-1:0] ex;
    logic [MAN_W-1:0] man;
    logic [SIG_W:0]   sum;
  } add_t;

endpackage

// File: rtl/lzc53.sv
// Leading-zero counter over 53 bits; all-zero input
// reports 53.
module lzc53 (
  input  logic [52:0] x,
  output logic [5:0]  cnt
);

  always_comb begin
    cnt = 6'd53;
    for (int i = 0; i < 53; i++)
      if (x[i]) cnt = 6'(52 - i);
  end

endmodule

// File: rtl/fp64_sub_pipe.sv
// Three-stage truncating double subtractor a - b with a
// valid/ready handshake and one shared stall enable.
module fp64_sub_pipe
  import fp64_pkg::*;
#(
  parameter int STAGES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result
);

  logic [STAGES-1:0] v;
  logic              en;
  align_t            s1_d, s1_q;
  add_t              s2_d, s2_q;
  logic [63:0]       res, r3;

  assign en        = !(v[STAGES-1] && !out_ready);
  assign in_ready  = en;
  assign out_valid = v[STAGES-1];
  assign result    = r3;

  logic [63:0] nb, x, y;
  logic        swap;
  logic [11:0] d;
  logic [52:0] mys;

  assign nb   = {~b[63], b[62:0]};
  assign swap = nb[62:0] > a[62:0];
  assign x    = swap ? nb : a;
  assign y    = swap ? a : nb;
  assign d    = {1'b0, x[62:52]} - {1'b0, y[62:52]};

  always_comb begin
    mys = {|y[62:52], y[51:0]};
    if (d >= 12'd64) mys = '0;
    else             mys = mys >> d;
  end

  always_comb begin
    s1_d     = '0;
    s1_d.sx  = x[63];
    s1_d.ex  = x[62:52];
    s1_d.sub = x[63] ^ y[63];
    s1_d.mx  = {|x[62:52], x[51:0]};
    s1_d.my  = mys;
    // Priority matters: NaN/Inf inputs beat zero pass-through
    if (&a[62:52] || &b[62:52])
      s1_d.cls = SAT;
    else if (a[62:0] == '0 && b[62:0] == '0)
      s1_d.cls = ZERO;
    else if (a[62:0] == '0)
      s1_d.cls = PASS_NB;
    else if (b[62:0] == '0)
      s1_d.cls = PASS_A;
    else
      s1_d.cls = NORMAL;
  end

  always_comb begin
    s2_d     = '0;
    s2_d.cls = s1_q.cls;
    s2_d.sx  = s1_q.sx;
    s2_d.ex  = s1_q.ex;
    s2_d.man = s1_q.mx[51:0];
    if (s1_q.sub)
      s2_d.sum = {1'b0, s1_q.mx} - {1'b0, s1_q.my};
    else
      s2_d.sum = {1'b0, s1_q.mx} + {1'b0, s1_q.my};
  end

  logic [5:0]  lz;
  logic [11:0] e_n;
  logic [51:0] m_n;
  logic        uf;

  lzc53 u_lzc (
    .x   (s2_q.sum[52:0]),
    .cnt (lz)
  );

  always_comb begin
    e_n = {1'b0, s2_q.ex};
    m_n = s2_q.sum[51:0];
    uf  = 1'b0;
    if (s2_q.sum[53]) begin
      e_n = {1'b0, s2_q.ex} + 12'd1;
      m_n = s2_q.sum[52:1];
    end else if (!s2_q.sum[52]) begin
      // bit 52 is clear here, so the leading one falls off the top
      m_n = s2_q.sum[51:0] << lz;
      e_n = {1'b0, s2_q.ex} - {6'b0, lz};
      uf  = {6'b0, lz} >= {1'b0, s2_q.ex};
    end
  end

  always_comb begin
    res = FP64_ZERO;
    unique case (s2_q.cls)
      SAT:     res = FP64_SAT;
      ZERO:    res = FP64_ZERO;
      PASS_A,
      PASS_NB: res = {s2_q.sx, s2_q.ex, s2_q.man};
      NORMAL: begin
        if (s2_q.sum == '0)
          res = FP64_ZERO;
        else if (e_n == 12'h7FF)
          res = FP64_SAT;
        else if (uf)
          res = {s2_q.sx, 63'b0};
        else
          res = {s2_q.sx, e_n[10:0], m_n};
      end
      default: res = FP64_ZERO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v    <= '0;
      s1_q <= '0;
      s2_q <= '0;
      r3   <= '0;
    end else if (en) begin
      v    <= {v[STAGES-2:0], in_valid};
      s1_q <= s1_d;
      s2_q <= s2_d;
      r3   <= res;
    end
  end

endmodule

// File: tb/tb_fp64_sub_pipe.sv
// Directed bench for fp64_sub_pipe: value model plus
// scoreboard, stall, reset and latency checks.
module tb_fp64_sub_pipe;

  logic        clk = 0;
  logic        rst, in_valid, in_ready;
  logic        out_valid, out_ready;
  logic [63:0] a, b, result;

  int checks = 0;
  int errors = 0;

  logic [63:0] q[$];
  logic [63:0] expv, held;
  logic        stall_prev = 0;
  logic        saw_stall = 0;
  int          outs = 0;

  localparam logic [63:0] SATV = 64'h7FFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  fp64_sub_pipe #(.STAGES(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  // Value-level model: align, add, renormalise with loops
  function automatic logic [63:0] model(
    input logic [63:0] x, input logic [63:0] y);
    logic [63:0] nb, big, sml;
    longint unsigned mb, ms, s;
    int e, sh;
    bit shifted;
    nb = y;
    nb[63] = ~y[63];
    if (x[62:52] == 11'h7FF || y[62:52] == 11'h7FF)
      return SATV;
    if (x[62:0] == 0 && y[62:0] == 0) return 64'h0;
    if (x[62:0] == 0) return nb;
    if (y[62:0] == 0) return x;
    if (nb[62:0] > x[62:0]) begin
      big = nb; sml = x;
    end else begin
      big = x; sml = nb;
    end
    mb = {11'b0, big[62:52] != 0, big[51:0]};
    ms = {11'b0, sml[62:52] != 0, sml[51:0]};
    sh = int'(big[62:52]) - int'(sml[62:52]);
    ms = (sh >= 64) ? 64'd0 : ms >> sh;
    s = (big[63] == sml[63]) ? mb + ms : mb - ms;
    if (s == 0) return 64'h0;
    e = int'(big[62:52]);
    shifted = 0;
    while (s >= (64'd1 << 53)) begin
      s = s >> 1; e++;
    end
    while (s < (64'd1 << 52)) begin
      s = s << 1; e--; shifted = 1;
    end
    if (e >= 2047) return SATV;
    if (shifted && e <= 0) return {big[63], 63'b0};
    return {big[63], 11'(e), s[51:0]};
  endfunction

  task automatic pin(input string nm,
    input logic [63:0] x, input logic [63:0] y,
    input logic [63:0] want);
    logic [63:0] got;
    got = model(x, y);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL model_%s got %h want %h",
               nm, got, want);
    end
  endtask

  task automatic chk(input string nm,
    input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  always @(posedge clk) begin
    if (rst) q.delete();
    else if (in_valid && in_ready) q.push_back(model(a, b));
  end

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
    end else begin
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        errors++;
        $display("FAIL in_ready got %b ov %b or %b",
                 in_ready, out_valid, out_ready);
      end
      if (!in_ready) saw_stall = 1;
      if (stall_prev) begin
        checks++;
        if (!out_valid || result !== held) begin
          errors++;
          $display("FAIL stall_hold got %b/%h want 1/%h",
                   out_valid, result, held);
        end
      end
      if (out_valid && out_ready) begin
        outs++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out got %h want none",
                   result);
        end else begin
          expv = q.pop_front();
          if (result !== expv) begin
            errors++;
            $display("FAIL result got %h want %h",
                     result, expv);
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      held = result;
    end
  end

  task automatic send(input logic [63:0] x,
                      input logic [63:0] y);
    int g;
    bit ok;
    g = 0;
    a = x;
    b = y;
    in_valid = 1;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      g++;
    end while (!ok && g < 100);
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout got 0 want 1");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d want 0",
               q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic lat_test(input logic [63:0] x,
    input logic [63:0] y, input logic [63:0] want);
    int lat;
    a = x;
    b = y;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL latency got %0d want 3", lat);
    end
    chk("lat_result", result, want);
  endtask

  initial begin
    rst = 1;
    in_valid = 0;
    a = 0;
    b = 0;
    out_ready = 1;

    pin("diff", 64'h402C000000000000,
        64'h4020000000000000, 64'h4018000000000000);
    pin("opp", 64'h4000000000000000,
        64'hC008000000000000, 64'h4014000000000000);
    pin("cancel", 64'h3FF0000000000000,
        64'h3FF0000000000000, 64'h0);
    pin("a_zero", 64'h0,
        64'h40291EB851EB851F, 64'hC0291EB851EB851F);
    pin("b_zero", 64'h40291EB851EB851F,
        64'h0, 64'h40291EB851EB851F);
    pin("sat", 64'h7FF0000000000000,
        64'h3FF0000000000000, SATV);
    pin("ovf", 64'h7FEFFFFFFFFFFFFF,
        64'hFFEFFFFFFFFFFFFF, SATV);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_result", result, 64'h0);
    rst = 0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'h1);

    lat_test(64'h402C000000000000,
             64'h4020000000000000, 64'h4018000000000000);
    drain();

    send(64'h4000000000000000, 64'hC008000000000000);
    send(64'h3FF0000000000000, 64'h3FF0000000000000);
    send(64'h0, 64'h40291EB851EB851F);
    send(64'h40291EB851EB851F, 64'h0);
    send(64'h0, 64'h0);
    send(64'h7FF0000000000000, 64'h3FF0000000000000);
    send(64'h7FEFFFFFFFFFFFFF, 64'hFFEFFFFFFFFFFFFF);
    send(64'h3FF0000000000000, 64'h3FEFFFFFFFFFFFFF);
    send(64'h0010000000000000, 64'h000FFFFFFFFFFFFF);
    send(64'h4341C37937E08000, 64'h3FF8000000000000);
    drain();

    outs = 0;
    saw_stall = 0;
    fork
      begin
        send(64'h4008000000000000, 64'h3FF0000000000000);
        send(64'h3FF0000000000000, 64'h3FE8000000000000);
        send(64'h3FF8000000000000, 64'hBFE0000000000000);
        send(64'h4024000000000000, 64'h4004000000000000);
        send(64'hC024000000000000, 64'h4059000000000000);
        in_valid = 0;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1;
      end
    join
    drain();
    checks++;
    if (!saw_stall) begin
      errors++;
      $display("FAIL bp_stall got 0 want 1");
    end
    chk("bp_count", 64'(outs), 64'd5);

    send(64'h4008000000000000, 64'h3FF0000000000000);
    send(64'h4024000000000000, 64'h4004000000000000);
    send(64'h3FF8000000000000, 64'hBFE0000000000000);
    in_valid = 0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    chk("midrst_out_valid", 64'(out_valid), 64'h0);
    chk("midrst_result", result, 64'h0);
    chk("midrst_in_ready", 64'(in_ready), 64'h1);
    outs = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_stale", 64'(outs), 64'd0);

    lat_test(64'h4000000000000000,
             64'hC008000000000000, 64'h4014000000000000);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
